// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Wrap-bit pointers give full/empty/count directly; flush and reset clear only the pointers.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [63:0]              enq_pc,
    input  logic [31:0]              enq_instr,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [63:0]              deq_pc,
    output logic [31:0]              deq_instr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0] pc_mem    [DEPTH];
    logic [31:0] instr_mem [DEPTH];

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          enq_fire;
    logic          deq_fire;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    // Status is derived purely from the registered pointers, so it never
    // depends on same-cycle handshake inputs.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count     = wr_ptr - rd_ptr;
    assign enq_ready = ~full;
    assign deq_valid = ~empty;

    // Flush squashes both sides of the handshake in the same cycle.
    assign enq_fire = enq_valid & enq_ready & ~flush;
    assign deq_fire = deq_valid & deq_ready & ~flush;

    // Head entry is read straight from storage; forced to zero when nothing is held.
    always_comb begin
        deq_pc    = '0;
        deq_instr = '0;
        if (!empty) begin
            deq_pc    = pc_mem[rd_idx];
            deq_instr = instr_mem[rd_idx];
        end
    end

    // Storage write: data only, never reset or cleared.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[wr_idx]    <= enq_pc;
            instr_mem[wr_idx] <= enq_instr;
        end
    end

    // Pointer update: reset is asynchronous, flush wins over enqueue/dequeue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (DEPTH = 4): directed vectors plus a
// randomized run against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [63:0] enq_pc;
    logic [31:0] enq_instr;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_instr;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int errors = 0;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_pc    (enq_pc),
        .enq_instr (enq_instr),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_pc    (deq_pc),
        .deq_instr (deq_instr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [63:0] pc, input logic [31:0] ins,
                         input logic dr, input logic fl);
        enq_valid = ev;
        enq_pc    = pc;
        enq_instr = ins;
        deq_ready = dr;
        flush     = fl;
    endtask

    logic [95:0] q[$];
    logic        ev_r, dr_r, fl_r;

    initial begin
        rst = 1'b0;
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);

        // Reset asserted mid-cycle: outputs must settle without a clock edge.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_enq_ready", enq_ready, 1);
        chk("rst_deq_valid", deq_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_deq_pc", deq_pc, 0);
        chk("rst_deq_instr", deq_instr, 0);
        tick();
        #2 rst = 1'b0;
        tick();
        chk("idle_empty", empty, 1);

        // Fill to DEPTH with decode stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h13 + 32'(i), 1'b0, 1'b0);
            tick();
            if (i == 0) begin
                chk("first_vis_pc", deq_pc, 64'h8000_0000);
                chk("first_vis_cnt", count, 1);
            end
        end
        chk("fill_full", full, 1);
        chk("fill_count", count, 4);
        chk("fill_enq_ready", enq_ready, 0);
        drive(1'b1, 64'h8000_0010, 32'h17, 1'b0, 1'b0);
        tick();
        chk("over_count", count, 4);
        chk("over_head", deq_pc, 64'h8000_0000);

        // Drain in order, one per cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            chk("drain_pc", deq_pc, 64'h8000_0000 + 64'(4 * i));
            chk("drain_instr", deq_instr, 32'h13 + 32'(i));
            chk("drain_count", count, 96'(4 - i));
            tick();
        end
        chk("drain_empty", empty, 1);
        chk("drain_deq_valid", deq_valid, 0);
        chk("drain_deq_pc", deq_pc, 0);

        // Full queue with simultaneous enqueue and dequeue: only the dequeue fires.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h8000_0100 + 64'(4 * i), 32'h100 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'h8000_0110, 32'h104, 1'b1, 1'b0);
        chk("fe_head", deq_pc, 64'h8000_0100);
        tick();
        chk("fe_count3", count, 3);
        chk("fe_head2", deq_pc, 64'h8000_0104);
        drive(1'b1, 64'h8000_0110, 32'h104, 1'b0, 1'b0);
        tick();
        chk("fe_count4", count, 4);
        chk("fe_full", full, 1);
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
            chk("fe_drain_pc", deq_pc, 64'h8000_0100 + 64'(4 * i));
            chk("fe_drain_instr", deq_instr, 32'h100 + 32'(i));
            tick();
        end
        chk("fe_empty", empty, 1);

        // Back-to-back streaming across several pointer wraps.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'h8000_0000 + 64'(4 * i), 32'(i), 1'b1, 1'b0);
            if (i > 0) begin
                chk("str_valid", deq_valid, 1);
                chk("str_pc", deq_pc, 64'h8000_0000 + 64'(4 * (i - 1)));
                chk("str_instr", deq_instr, 32'(i - 1));
                chk("str_count", count, 1);
            end else begin
                chk("str_count0", count, 0);
            end
            tick();
        end
        drive(1'b0, 64'h0, 32'h0, 1'b1, 1'b0);
        chk("str_last_pc", deq_pc, 64'h8000_004C);
        tick();
        chk("str_end_empty", empty, 1);

        // Flush beats a simultaneous enqueue and dequeue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h8000_0200 + 64'(4 * i), 32'h200 + 32'(i), 1'b0, 1'b0);
            tick();
        end
        chk("fl_count3", count, 3);
        drive(1'b1, 64'h8000_0300, 32'h300, 1'b1, 1'b1);
        tick();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_empty", empty, 1);
        chk("fl_deq_valid", deq_valid, 0);
        chk("fl_count", count, 0);
        chk("fl_deq_pc", deq_pc, 0);
        drive(1'b1, 64'h8000_1000, 32'hABC, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_after_valid", deq_valid, 1);
        chk("fl_after_pc", deq_pc, 64'h8000_1000);
        chk("fl_after_instr", deq_instr, 32'hABC);
        chk("fl_after_count", count, 1);

        // Asynchronous reset in the middle of operation.
        drive(1'b1, 64'h8000_2000, 32'h55, 1'b0, 1'b0);
        tick();
        drive(1'b0, 64'h0, 32'h0, 1'b0, 1'b0);
        chk("mr_count2", count, 2);
        #3 rst = 1'b1;
        #1;
        chk("mr_empty", empty, 1);
        chk("mr_count", count, 0);
        chk("mr_deq_valid", deq_valid, 0);
        chk("mr_deq_pc", deq_pc, 0);
        #2 rst = 1'b0;
        tick();

        // Randomized traffic against a queue model.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            ev_r = ($urandom_range(0, 99) < 70);
            dr_r = ($urandom_range(0, 99) < 60);
            fl_r = ($urandom_range(0, 99) < 5);
            drive(ev_r, {$urandom, $urandom}, $urandom, dr_r, fl_r);
            chk("rnd_count", count, 96'(q.size()));
            chk("rnd_full", full, (q.size() == DEPTH));
            chk("rnd_empty", empty, (q.size() == 0));
            chk("rnd_enq_ready", enq_ready, (q.size() != DEPTH));
            if (q.size() > 0) chk("rnd_head", {deq_pc, deq_instr}, q[0]);
            else              chk("rnd_head0", {deq_pc, deq_instr}, 96'h0);
            if (fl_r) begin
                q.delete();
            end else begin
                logic was_full;
                was_full = (q.size() == DEPTH);
                if (dr_r && q.size() > 0) void'(q.pop_front());
                if (ev_r && !was_full) q.push_back({enq_pc, enq_instr});
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
